// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the filter-bank sequencer.
package fb_pkg;

  localparam int NADDR = 64;
  localparam int AW    = 6;
  localparam int RDLAT = 2;
  localparam int DW    = 16;
  localparam int CW    = 36;
  localparam int NFILT = 8;
  localparam int SELW  = $clog2(NFILT);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic [CW-1:0]        coeff_t;
  typedef logic [AW-1:0]        caddr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [NFILT-1:0] sel_onehot(input logic [SELW-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/fb_seq_ctrl_strobe_delay.sv
// Delays the {issue, first} flags by the coefficient read latency so the
// accumulator strobes line up with products arriving at the MAC input.
module fb_strobe_delay
  import fb_pkg::*;
#(
  parameter int DEPTH = RDLAT
) (
  input  logic clock,
  input  logic reset,
  input  logic issue_i,
  input  logic first_i,
  output logic acc_en_o,
  output logic acc_clr_o
);

  logic [DEPTH-1:0] issue_q;
  logic [DEPTH-1:0] first_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_q <= '0;
      first_q <= '0;
    end else begin
      issue_q[0] <= issue_i;
      first_q[0] <= first_i;
      for (int i = 1; i < DEPTH; i++) begin
        issue_q[i] <= issue_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign acc_en_o  = issue_q[DEPTH-1];
  assign acc_clr_o = first_q[DEPTH-1];

endmodule

// File: rtl/fb_seq_ctrl.sv
// Sweep sequencer for the 8-channel filter bank, with a one-deep sample
// buffer and host arbitration of the shared coefficient RAM port.
module fb_seq_ctrl
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              din_enable,
  input  sample_t           datain,
  output sample_t           sample_out,
  output logic              shift_en,
  output caddr_t            coeff_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr,
  input  logic              host_wr_req,
  input  caddr_t            host_wr_addr,
  input  logic [SELW-1:0]   host_wr_sel,
  input  coeff_t            host_wr_data,
  output logic              host_wr_ack,
  output logic [NFILT-1:0]  coeff_we,
  output coeff_t            coeff_wdata
);

  localparam int DCW = $clog2(RDLAT + 1);
  localparam caddr_t          LAST_ADDR  = caddr_t'(NADDR - 1);
  localparam logic [DCW-1:0]  LAST_DRAIN = DCW'(RDLAT - 1);

  state_t          state_q, state_d;
  caddr_t          addr_q, addr_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            pending_q, pending_d;
  sample_t         buf_q, buf_d;
  sample_t         held_q, held_d;
  logic            overrun_q, overrun_d;

  logic issue;
  logic first;
  logic drop;
  logic grant;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    shift_en  = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    first     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          shift_en = 1'b1;
          addr_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        first = (addr_q == '0);
        // Counter parks at the last address rather than wrapping.
        if (addr_q == LAST_ADDR) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A sample arriving in the consume cycle refills the buffer without overrun.
  always_comb begin
    pending_d = pending_q;
    buf_d     = buf_q;
    drop      = 1'b0;
    if (din_enable) begin
      if (!pending_q || shift_en) begin
        buf_d     = datain;
        pending_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (shift_en) begin
      pending_d = 1'b0;
    end
    overrun_d = drop | (overrun_q & ~ovr_clr);
    held_d    = shift_en ? buf_q : held_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      buf_q     <= '0;
      held_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
      buf_q     <= buf_d;
      held_q    <= held_d;
      overrun_q <= overrun_d;
    end
  end

  fb_strobe_delay #(
    .DEPTH (RDLAT)
  ) u_strobe_delay (
    .clock     (clock),
    .reset     (reset),
    .issue_i   (issue),
    .first_i   (first),
    .acc_en_o  (acc_en),
    .acc_clr_o (acc_clr)
  );

  // Host only gets the port when nothing is running or waiting to run.
  assign grant       = (state_q == IDLE) && !pending_q && host_wr_req && !reset;
  assign host_wr_ack = grant;
  assign coeff_we    = grant ? sel_onehot(host_wr_sel) : '0;
  assign coeff_wdata = grant ? host_wr_data : '0;
  assign coeff_addr  = grant ? host_wr_addr :
                       (state_q == ISSUE) ? addr_q : '0;
  assign sample_out  = shift_en ? buf_q : held_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule
